sc_endgame_detector: RTL and testbench



---
 rtl/sc_game_pkg.sv | 20 ++
 rtl/sc_endgame_detector_if.sv | 35 +++
 rtl/sc_cycle_counter.sv | 46 ++++
 rtl/sc_endgame_detector.sv | 150 +++++++++++++++
 tb/tb_sc_endgame_detector.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_game_pkg.sv
// Shared game constants: master state codes, end-game detector state codes
// and default lives count.
package sc_game_pkg;

    // Master game state machine encoding.
    localparam int         STATE_DATAWIDTH = 2;
    localparam logic [1:0] MS_AWAITSTART   = 2'd0;
    localparam logic [1:0] MS_STARTGAME    = 2'd1;
    localparam logic [1:0] MS_ENDGAME      = 2'd2;

    // End-game detector state encoding.
    localparam logic [1:0] ED_IDLE    = 2'd0;
    localparam logic [1:0] ED_ARMED   = 2'd1;
    localparam logic [1:0] ED_HOLDOFF = 2'd2;
    localparam logic [1:0] ED_DEAD    = 2'd3;

    // Lives granted at the start of each game.
    localparam int LIVES_INIT_DEFAULT = 3;

endpackage

// File: rtl/sc_endgame_detector_if.sv
// Signal bundle between the game master / collision logic (master side)
// and the end-game detector (slave side).
interface sc_endgame_detector_if #(
    parameter int LIVES_DATAWIDTH = 2
) ();
    import sc_game_pkg::*;

    logic [STATE_DATAWIDTH-1:0] SC_ENDGAME_DETECTOR_MasterState_In;
    logic                       SC_ENDGAME_DETECTOR_LoadSignal_In;
    logic                       SC_ENDGAME_DETECTOR_Collision_InLow;
    logic                       SC_ENDGAME_DETECTOR_GoalReached_InLow;
    logic                       SC_ENDGAME_DETECTOR_EndGameSignal_OutLow;
    logic [LIVES_DATAWIDTH-1:0] SC_ENDGAME_DETECTOR_Lives_Out;
    logic                       SC_ENDGAME_DETECTOR_Holdoff_Out;

    modport master (
        output SC_ENDGAME_DETECTOR_MasterState_In,
        output SC_ENDGAME_DETECTOR_LoadSignal_In,
        output SC_ENDGAME_DETECTOR_Collision_InLow,
        output SC_ENDGAME_DETECTOR_GoalReached_InLow,
        input  SC_ENDGAME_DETECTOR_EndGameSignal_OutLow,
        input  SC_ENDGAME_DETECTOR_Lives_Out,
        input  SC_ENDGAME_DETECTOR_Holdoff_Out
    );

    modport slave (
        input  SC_ENDGAME_DETECTOR_MasterState_In,
        input  SC_ENDGAME_DETECTOR_LoadSignal_In,
        input  SC_ENDGAME_DETECTOR_Collision_InLow,
        input  SC_ENDGAME_DETECTOR_GoalReached_InLow,
        output SC_ENDGAME_DETECTOR_EndGameSignal_OutLow,
        output SC_ENDGAME_DETECTOR_Lives_Out,
        output SC_ENDGAME_DETECTOR_Holdoff_Out
    );
endinterface

// File: rtl/sc_cycle_counter.sv
// Width/terminal-count parameterised cycle counter with synchronous clear,
// count enable and a terminal flag. Wraps to zero after the terminal count,
// so it never exceeds TERMINAL.
module sc_cycle_counter #(
    parameter int WIDTH    = 5,
    parameter int TERMINAL = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] count_o,
    output logic             terminal_o
);
    localparam logic [WIDTH-1:0] TC = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins over enable; wrap at terminal count.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            if (count_q == TC) begin
                count_d = '0;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign terminal_o = (count_q == TC);

endmodule

// File: rtl/sc_endgame_detector.sv
// Lives and end-of-game controller. Counts lives down on collisions with a
// post-hit invulnerability window and pulls the active-low end-game request
// low once the last life is lost.
// Optional round time limit: define SC_ENDGAME_DETECTOR_ROUND_TIMEOUT_EN.
module sc_endgame_detector
    import sc_game_pkg::*;
#(
    parameter int LIVES_INIT        = LIVES_INIT_DEFAULT,
    parameter int LIVES_DATAWIDTH   = 2,
    parameter int HOLDOFF_CYCLES    = 16,
    parameter int HOLDOFF_DATAWIDTH = 5,
    parameter int ROUND_CYCLES      = 1024,
    parameter int ROUND_DATAWIDTH   = 10
) (
    input logic                  SC_ENDGAME_DETECTOR_CLOCK_50,
    input logic                  SC_ENDGAME_DETECTOR_RESET_InHigh,
    sc_endgame_detector_if.slave bus
);
    localparam logic [LIVES_DATAWIDTH-1:0] LIVES_RELOAD = LIVES_DATAWIDTH'(LIVES_INIT);
    localparam logic [LIVES_DATAWIDTH-1:0] LIVES_ONE    = LIVES_DATAWIDTH'(1);

    logic                       clk;
    logic                       rst;
    logic                       load;
    logic                       hit;
    logic [1:0]                 state_q;
    logic [1:0]                 state_d;
    logic [LIVES_DATAWIDTH-1:0] lives_q;
    logic [LIVES_DATAWIDTH-1:0] lives_d;
    logic                       in_play;
    logic                       hold_done;
    logic                       round_timeout;
    logic [HOLDOFF_DATAWIDTH-1:0] hold_count;

    assign clk     = SC_ENDGAME_DETECTOR_CLOCK_50;
    assign rst     = SC_ENDGAME_DETECTOR_RESET_InHigh;
    assign load    = bus.SC_ENDGAME_DETECTOR_LoadSignal_In;
    assign hit     = ~bus.SC_ENDGAME_DETECTOR_Collision_InLow;
    assign in_play = (state_q == ED_ARMED) || (state_q == ED_HOLDOFF);

    // Invulnerability window: runs only in HOLDOFF, cleared on abort so a
    // fresh game always starts from zero.
    sc_cycle_counter #(
        .WIDTH    (HOLDOFF_DATAWIDTH),
        .TERMINAL (HOLDOFF_CYCLES - 1)
    ) u_holdoff_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    ((state_q != ED_HOLDOFF) || !load),
        .enable_i   (state_q == ED_HOLDOFF),
        .count_o    (hold_count),
        .terminal_o (hold_done)
    );

`ifdef SC_ENDGAME_DETECTOR_ROUND_TIMEOUT_EN
    logic                       round_tc;
    logic [ROUND_DATAWIDTH-1:0] round_count;
    logic                       unused_round_count;

    // Round timer: runs while playing, restarted by every goal.
    sc_cycle_counter #(
        .WIDTH    (ROUND_DATAWIDTH),
        .TERMINAL (ROUND_CYCLES - 1)
    ) u_round_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (!in_play || !load || !bus.SC_ENDGAME_DETECTOR_GoalReached_InLow),
        .enable_i   (in_play),
        .count_o    (round_count),
        .terminal_o (round_tc)
    );

    assign round_timeout      = round_tc && in_play;
    assign unused_round_count = ^round_count;
`else
    localparam int unused_round_cfg = ROUND_CYCLES + ROUND_DATAWIDTH;
    logic unused_goal;

    assign round_timeout = 1'b0;
    assign unused_goal   = bus.SC_ENDGAME_DETECTOR_GoalReached_InLow;
`endif

    logic unused_hold_count;
    assign unused_hold_count = ^hold_count;

    // Next state and lives: abort first, then collision/timeout, then
    // hold-off expiry. Lives reload on every entry into IDLE.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        case (state_q)
            ED_IDLE: begin
                lives_d = LIVES_RELOAD;
                if (load && (bus.SC_ENDGAME_DETECTOR_MasterState_In == MS_STARTGAME)) begin
                    state_d = ED_ARMED;
                end
            end
            ED_ARMED: begin
                if (!load) begin
                    state_d = ED_IDLE;
                    lives_d = LIVES_RELOAD;
                end else if (round_timeout || (hit && (lives_q <= LIVES_ONE))) begin
                    state_d = ED_DEAD;
                    lives_d = '0;
                end else if (hit) begin
                    state_d = ED_HOLDOFF;
                    lives_d = lives_q - LIVES_ONE;
                end
            end
            ED_HOLDOFF: begin
                if (!load) begin
                    state_d = ED_IDLE;
                    lives_d = LIVES_RELOAD;
                end else if (round_timeout) begin
                    state_d = ED_DEAD;
                    lives_d = '0;
                end else if (hold_done) begin
                    state_d = ED_ARMED;
                end
            end
            ED_DEAD: begin
                lives_d = '0;
                if (!load) begin
                    state_d = ED_IDLE;
                    lives_d = LIVES_RELOAD;
                end
            end
            default: begin
                state_d = ED_IDLE;
                lives_d = LIVES_RELOAD;
            end
        endcase
    end

    // State and lives registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ED_IDLE;
            lives_q <= LIVES_RELOAD;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
        end
    end

    assign bus.SC_ENDGAME_DETECTOR_EndGameSignal_OutLow = (state_q != ED_DEAD);
    assign bus.SC_ENDGAME_DETECTOR_Holdoff_Out          = (state_q == ED_HOLDOFF);
    assign bus.SC_ENDGAME_DETECTOR_Lives_Out            = lives_q;

endmodule

// File: tb/tb_sc_endgame_detector.sv
// Bench for sc_endgame_detector: directed scenarios plus a randomized run
// checked against a behavioural lives/invulnerability model.
module tb_sc_endgame_detector;
    localparam int LIVES = 3;
    localparam int HOLD  = 16;
    localparam int ROUND = 64;
`ifdef SC_ENDGAME_DETECTOR_ROUND_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ms = 2'b00;
    logic       load = 1'b0;
    logic       coll_n = 1'b1;
    logic       goal_n = 1'b1;
    logic       eg;
    logic       ho;
    logic [1:0] lives;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: playing/dead flags, life count, remaining
    // invulnerable cycles and cycles since round start/last goal.
    bit m_playing = 0;
    bit m_dead = 0;
    int m_lives = LIVES;
    int m_hold = 0;
    int m_round = 0;

    sc_endgame_detector_if #(.LIVES_DATAWIDTH(2)) bus ();

    assign bus.SC_ENDGAME_DETECTOR_MasterState_In    = ms;
    assign bus.SC_ENDGAME_DETECTOR_LoadSignal_In     = load;
    assign bus.SC_ENDGAME_DETECTOR_Collision_InLow   = coll_n;
    assign bus.SC_ENDGAME_DETECTOR_GoalReached_InLow = goal_n;
    assign eg    = bus.SC_ENDGAME_DETECTOR_EndGameSignal_OutLow;
    assign ho    = bus.SC_ENDGAME_DETECTOR_Holdoff_Out;
    assign lives = bus.SC_ENDGAME_DETECTOR_Lives_Out;

    sc_endgame_detector #(
        .LIVES_INIT        (LIVES),
        .LIVES_DATAWIDTH   (2),
        .HOLDOFF_CYCLES    (HOLD),
        .HOLDOFF_DATAWIDTH (5),
        .ROUND_CYCLES      (ROUND),
        .ROUND_DATAWIDTH   (10)
    ) dut (
        .SC_ENDGAME_DETECTOR_CLOCK_50     (clk),
        .SC_ENDGAME_DETECTOR_RESET_InHigh (rst),
        .bus                              (bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_playing = 0;
        m_dead    = 0;
        m_lives   = LIVES;
        m_hold    = 0;
        m_round   = 0;
    endtask

    // Advance one clock: compute the model's next values from the current
    // inputs, let the edge pass, then commit.
    task automatic tick();
        bit np = m_playing;
        bit nd = m_dead;
        int nl = m_lives;
        int nh = m_hold;
        int nr = m_round;
        if (m_dead) begin
            if (!load) begin
                nd = 0;
                nl = LIVES;
            end
        end else if (!m_playing) begin
            nl = LIVES;
            nh = 0;
            nr = 0;
            if (load && ms == 2'b01) np = 1;
        end else if (!load) begin
            np = 0;
            nl = LIVES;
            nh = 0;
            nr = 0;
        end else begin
            if (TIMEOUT_EN && m_round == ROUND - 1) begin
                np = 0; nd = 1; nl = 0; nh = 0;
            end else if (!coll_n && m_hold == 0) begin
                if (m_lives <= 1) begin
                    np = 0; nd = 1; nl = 0; nh = 0;
                end else begin
                    nl = m_lives - 1;
                    nh = HOLD;
                end
            end else if (m_hold > 0) begin
                nh = m_hold - 1;
            end
            nr = (!goal_n) ? 0 : m_round + 1;
        end
        @(posedge clk);
        #1;
        m_playing = np; m_dead = nd; m_lives = nl; m_hold = nh; m_round = nr;
    endtask

    task automatic start_game();
        ms = 2'b01; load = 1'b1; coll_n = 1'b1; goal_n = 1'b1;
        tick();
    endtask

    task automatic end_game();
        coll_n = 1'b1; load = 1'b0; ms = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        model_reset();
        n_vec++;
        if ({eg, ho, lives} !== {1'b1, 1'b0, 2'd3}) begin
            $display("FAIL reset: eg/ho/lives = %b/%b/%0d, expected 1/0/3", eg, ho, lives);
            n_err++;
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_vec++;
        if ({eg, ho, lives} !== {1'b1, 1'b0, 2'd3}) begin
            $display("FAIL idle_after_reset: eg/ho/lives = %b/%b/%0d, expected 1/0/3", eg, ho, lives);
            n_err++;
        end
    endtask

    task automatic test_start();
        ms = 2'b00; load = 1'b1;
        tick();
        coll_n = 1'b0;
        tick();
        n_vec++;
        if ({eg, ho, lives} !== {1'b1, 1'b0, 2'd3}) begin
            $display("FAIL no_start_in_await: eg/ho/lives = %b/%b/%0d, expected 1/0/3", eg, ho, lives);
            n_err++;
        end
        start_game();
        n_vec++;
        if ({eg, ho, lives} !== {1'b1, 1'b0, 2'd3}) begin
            $display("FAIL start: eg/ho/lives = %b/%b/%0d, expected 1/0/3", eg, ho, lives);
            n_err++;
        end
    endtask

    task automatic test_single_hit();
        coll_n = 1'b0;
        tick();
        coll_n = 1'b1;
        n_vec++;
        if ({ho, lives} !== {1'b1, 2'd2}) begin
            $display("FAIL single_hit: ho/lives = %b/%0d, expected 1/2", ho, lives);
            n_err++;
        end
        for (int i = 0; i < HOLD - 1; i++) begin
            coll_n = (i == 5) ? 1'b0 : 1'b1;
            tick();
            n_vec++;
            if ({eg, ho, lives} !== {1'b1, 1'b1, 2'd2}) begin
                $display("FAIL holdoff_window[%0d]: eg/ho/lives = %b/%b/%0d, expected 1/1/2", i, eg, ho, lives);
                n_err++;
            end
        end
        coll_n = 1'b1;
        tick();
        n_vec++;
        if ({ho, lives} !== {1'b0, 2'd2}) begin
            $display("FAIL holdoff_end: ho/lives = %b/%0d, expected 0/2", ho, lives);
            n_err++;
        end
    endtask

    task automatic test_three_hits();
        coll_n = 1'b0;
        tick();
        coll_n = 1'b1;
        n_vec++;
        if ({eg, ho, lives} !== {1'b1, 1'b1, 2'd1}) begin
            $display("FAIL second_hit: eg/ho/lives = %b/%b/%0d, expected 1/1/1", eg, ho, lives);
            n_err++;
        end
        repeat (HOLD) tick();
        coll_n = 1'b0;
        tick();
        n_vec++;
        if ({eg, ho, lives} !== {1'b0, 1'b0, 2'd0}) begin
            $display("FAIL last_hit: eg/ho/lives = %b/%b/%0d, expected 0/0/0", eg, ho, lives);
            n_err++;
        end
        repeat (3) tick();
        n_vec++;
        if ({eg, lives} !== {1'b0, 2'd0}) begin
            $display("FAIL dead_hold: eg/lives = %b/%0d, expected 0/0", eg, lives);
            n_err++;
        end
        coll_n = 1'b1; load = 1'b0; ms = 2'b10;
        tick();
        n_vec++;
        if ({eg, ho, lives} !== {1'b1, 1'b0, 2'd3}) begin
            $display("FAIL dead_to_idle: eg/ho/lives = %b/%b/%0d, expected 1/0/3", eg, ho, lives);
            n_err++;
        end
    endtask

    task automatic test_abort();
        int eg_low = 0;
        start_game();
        coll_n = 1'b0; tick(); coll_n = 1'b1;
        repeat (HOLD) tick();
        coll_n = 1'b0; tick(); coll_n = 1'b1;
        n_vec++;
        if ({ho, lives} !== {1'b1, 2'd1}) begin
            $display("FAIL abort_setup: ho/lives = %b/%0d, expected 1/1", ho, lives);
            n_err++;
        end
        tick();
        load = 1'b0; ms = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!eg) eg_low++;
        end
        n_vec++;
        if ({eg_low, ho, lives} !== {32'd0, 1'b0, 2'd3}) begin
            $display("FAIL abort: eg_low_cycles/ho/lives = %0d/%b/%0d, expected 0/0/3", eg_low, ho, lives);
            n_err++;
        end
    endtask

    task automatic test_held_collision();
        start_game();
        coll_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_vec++;
            if ({eg, lives} !== {1'b1, (k < 18) ? 2'd2 : 2'd1}) begin
                $display("FAIL held_collision[%0d]: eg/lives = %b/%0d, expected 1/%0d", k, eg, lives, (k < 18) ? 2 : 1);
                n_err++;
            end
        end
        end_game();
    endtask

    task automatic test_timeout();
        if (TIMEOUT_EN) begin
            start_game();
            repeat (ROUND - 1) tick();
            n_vec++;
            if (eg !== 1'b1) begin
                $display("FAIL timeout_early: eg = %b, expected 1", eg);
                n_err++;
            end
            tick();
            n_vec++;
            if ({eg, lives} !== {1'b0, 2'd0}) begin
                $display("FAIL timeout: eg/lives = %b/%0d, expected 0/0", eg, lives);
                n_err++;
            end
            end_game();
            start_game();
            for (int k = 1; k <= ROUND + 6; k++) begin
                goal_n = (k == 50) ? 1'b0 : 1'b1;
                tick();
            end
            goal_n = 1'b1;
            n_vec++;
            if (eg !== 1'b1) begin
                $display("FAIL goal_restart: eg = %b, expected 1", eg);
                n_err++;
            end
            end_game();
        end else begin
            start_game();
            repeat (ROUND + 4) tick();
            n_vec++;
            if ({eg, lives} !== {1'b1, 2'd3}) begin
                $display("FAIL no_timeout: eg/lives = %b/%0d, expected 1/3", eg, lives);
                n_err++;
            end
            end_game();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            load   = ($urandom_range(0, 99) > 2);
            ms     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            coll_n = ($urandom_range(0, 99) > 9);
            goal_n = ($urandom_range(0, 99) > 1);
            tick();
            n_vec++;
            if ({eg, ho, lives} !== {~m_dead, (m_playing && m_hold > 0), 2'(m_lives)}) begin
                $display("FAIL random[%0d]: eg/ho/lives = %b/%b/%0d, expected %b/%b/%0d",
                         c, eg, ho, lives, ~m_dead, (m_playing && m_hold > 0), m_lives);
                n_err++;
            end
        end
        end_game();
    endtask

    task automatic test_async_reset();
        start_game();
        coll_n = 1'b0; tick(); coll_n = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if ({eg, ho, lives} !== {1'b1, 1'b0, 2'd3}) begin
            $display("FAIL async_reset: eg/ho/lives = %b/%b/%0d, expected 1/0/3", eg, ho, lives);
            n_err++;
        end
        load = 1'b0; ms = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_start();
        test_single_hit();
        test_three_hits();
        test_abort();
        test_held_collision();
        test_timeout();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
